// File: rtl/multi_key_beep_pkg.sv
// Shared definitions for the multi-key debounce and beep-burst block.
// Holds the sequencer state encoding, a counter-width helper and the
// default cycle counts for a 50 MHz board clock.
package multi_key_beep_pkg;

  // Sequencer state encoding
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_ON   = 2'd1;
  localparam logic [1:0] STATE_OFF  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = STATE_IDLE,
    S_ON   = STATE_ON,
    S_OFF  = STATE_OFF
  } beep_state_e;

  // Default timing for a 50 MHz board: 20 ms debounce, 100 ms beep on/off
  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = CLK_HZ / 50;
  localparam int unsigned DEF_BEEP_ON_CYC  = CLK_HZ / 10;
  localparam int unsigned DEF_BEEP_OFF_CYC = CLK_HZ / 10;

  // ceil(log2(max_val)), never less than 1 bit
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(max_val)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_key_beep_key_debounce_ch.sv
// Single key channel: two-flop synchroniser followed by a debounce counter.
//   sys_clk   : system clock
//   rst_n     : asynchronous active-low reset
//   key_in    : raw active-low key pin (asynchronous)
//   key_value : debounced key level (registered, resets to 1)
//   key_flag  : one-cycle pulse when a debounced press (1->0) is accepted
module key_debounce_ch
  import multi_key_beep_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned CNT_W        = cnt_width(DEBOUNCE_CYC)
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_value,
  output logic key_flag
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ_c;
  logic             accept_c;

  // Level change is accepted once it has differed for DEBOUNCE_CYC evaluations
  assign differ_c = (sync_q[1] != key_value);
  assign accept_c = differ_c && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));

  // Synchroniser, debounce counter and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      key_value <= 1'b1;
      key_flag  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_in};
      key_flag <= accept_c && !sync_q[1];
      if (!differ_c) begin
        cnt_q <= '0;
      end else if (accept_c) begin
        cnt_q     <= '0;
        key_value <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_key_beep.sv
// Board-level key handler: debounces NUM_KEYS active-low keys and turns a
// press on key i into a burst of (i+1) beeps.
//   sys_clk   : system clock
//   rst_n     : asynchronous active-low reset
//   key       : raw active-low key pins
//   key_flag  : per-channel one-cycle press pulse
//   key_value : per-channel debounced level
//   beep      : buzzer drive (BEEP_ACTIVE sounds it)
//   busy      : high while a burst is in progress
module multi_key_beep
  import multi_key_beep_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
  parameter int unsigned BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
  parameter logic        BEEP_ACTIVE  = 1'b1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] key_value,
  output logic                beep,
  output logic                busy
);

  localparam int unsigned MAX_BEEP_CYC =
      (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int unsigned MAX_CYC =
      (DEBOUNCE_CYC > MAX_BEEP_CYC) ? DEBOUNCE_CYC : MAX_BEEP_CYC;
  localparam int unsigned CNT_W = cnt_width(MAX_CYC);
  localparam int unsigned REM_W = $clog2(NUM_KEYS + 1);

  // One debounce channel per key
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .key_in   (key[g]),
      .key_value(key_value[g]),
      .key_flag (key_flag[g])
    );
  end

  beep_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] load_rem_c;
  logic             beep_d;
  logic             busy_d;

  // Burst length for the lowest-index flag (index + 1)
  always_comb begin
    load_rem_c = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (key_flag[i]) load_rem_c = REM_W'(i + 1);
    end
  end

  // Sequencer next state; beep and busy follow the next state so they are
  // registered alongside it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (|key_flag) begin
          state_d = S_ON;
          cnt_d   = '0;
          rem_d   = load_rem_c;
        end
      end
      S_ON: begin
        if (cnt_q == CNT_W'(BEEP_ON_CYC - 1)) begin
          cnt_d   = '0;
          rem_d   = rem_q - REM_W'(1);
          state_d = (rem_q == REM_W'(1)) ? S_IDLE : S_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OFF: begin
        if (cnt_q == CNT_W'(BEEP_OFF_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_ON;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rem_d   = '0;
      end
    endcase
    beep_d = (state_d == S_ON) ? BEEP_ACTIVE : ~BEEP_ACTIVE;
    busy_d = (state_d != S_IDLE);
  end

  // Sequencer state and output registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      beep    <= ~BEEP_ACTIVE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      beep    <= beep_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_multi_key_beep.sv
// Bench for multi_key_beep: directed scenarios plus random key activity,
// checked cycle by cycle against a behavioural model through a queue.
module tb_multi_key_beep;

  localparam int unsigned NK  = 4;
  localparam int unsigned DB  = 8;
  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 3;
  localparam logic        ACT = 1'b1;
  localparam longint L_ON  = 4;
  localparam longint L_OFF = 3;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [NK-1:0] key     = '1;
  logic [NK-1:0] key_flag;
  logic [NK-1:0] key_value;
  logic          beep;
  logic          busy;

  multi_key_beep #(
    .NUM_KEYS    (NK),
    .DEBOUNCE_CYC(DB),
    .BEEP_ON_CYC (ON),
    .BEEP_OFF_CYC(OFF),
    .BEEP_ACTIVE (ACT)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .key      (key),
    .key_flag (key_flag),
    .key_value(key_value),
    .beep     (beep),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [NK-1:0] kv;
    logic [NK-1:0] flag;
    logic          beep;
    logic          busy;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   vectors     = 0;
  int unsigned   miscompares = 0;

  // Behavioural model state
  logic [NK-1:0] hist[$];      // pin samples, newest first
  logic [NK-1:0] m_kv;
  logic [NK-1:0] m_flag;
  longint        cyc     = 0;
  longint        b_start = 0;
  longint        b_len   = 0;
  logic          m_beep_now = 1'b0;
  bit            m_all;
  int            m_k;
  exp_t          m_e;

  function automatic bit in_burst(input longint c);
    return (c >= b_start) && (c < b_start + b_len);
  endfunction

  // Model: a level is accepted when the synchronised pin (2 samples old)
  // has disagreed with the accepted level for the last DB samples. A press
  // accepted while no burst is running schedules k*ON + (k-1)*OFF busy
  // cycles from the next cycle, beeping during the first ON of each period.
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      hist.delete();
      repeat (DB + 2) hist.push_back('1);
      m_kv       = '1;
      b_len      = 0;
      m_beep_now = 1'b0;
    end else begin
      hist.push_front(key);
      void'(hist.pop_back());
      m_flag = '0;
      for (int ch = 0; ch < int'(NK); ch++) begin
        m_all = 1'b1;
        for (int j = 2; j <= int'(DB) + 1; j++) begin
          if (hist[j][ch] == m_kv[ch]) m_all = 1'b0;
        end
        if (m_all) begin
          m_kv[ch] = ~m_kv[ch];
          if (!m_kv[ch]) m_flag[ch] = 1'b1;
        end
      end
      if (m_flag != '0 && !in_burst(cyc)) begin
        m_k = 0;
        for (int ch = int'(NK) - 1; ch >= 0; ch--) begin
          if (m_flag[ch]) m_k = ch + 1;
        end
        b_start = cyc + 1;
        b_len   = longint'(m_k) * L_ON + longint'(m_k - 1) * L_OFF;
      end
      m_e.kv   = m_kv;
      m_e.flag = m_flag;
      m_e.busy = in_burst(cyc);
      m_e.beep = (m_e.busy && (((cyc - b_start) % (L_ON + L_OFF)) < L_ON)) ? ACT : ~ACT;
      m_beep_now = (m_e.beep == ACT);
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compare on the falling edge; while in reset expect reset values
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      exp_q.delete();
      vectors = vectors + 1;
      if ({key_value, key_flag, beep, busy} !== {{NK{1'b1}}, {NK{1'b0}}, ~ACT, 1'b0}) begin
        miscompares = miscompares + 1;
        $display("FAIL reset_state t=%0t: kv=%b flag=%b beep=%b busy=%b, expected kv=%b flag=%b beep=%b busy=0",
                 $time, key_value, key_flag, beep, busy, {NK{1'b1}}, {NK{1'b0}}, ~ACT);
      end
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if ({key_value, key_flag, beep, busy} !== e) begin
        miscompares = miscompares + 1;
        $display("FAIL cycle_check t=%0t: kv=%b flag=%b beep=%b busy=%b, expected kv=%b flag=%b beep=%b busy=%b",
                 $time, key_value, key_flag, beep, busy, e.kv, e.flag, e.beep, e.busy);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #1 rst_n = 1'b0;
    key = '1;
    tick(3);
    @(posedge sys_clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    key   = '1;
    tick(3);
    @(posedge sys_clk);
    #2 rst_n = 1'b1;
    tick(5);

    // Clean press on key 2: three beeps
    @(negedge sys_clk);
    key[2] = 1'b0;
    tick(40);
    key[2] = 1'b1;
    tick(30);

    // Bounce on key 0, then a steady press
    for (int t = 0; t < 10; t++) begin
      key[0] = ~key[0];
      tick(3);
    end
    key[0] = 1'b0;
    tick(40);
    key[0] = 1'b1;
    tick(30);

    // Simultaneous press on keys 1 and 3
    key[1] = 1'b0;
    key[3] = 1'b0;
    tick(60);
    key = '1;
    tick(30);

    // Press on key 0 while a key 3 burst is running
    key[3] = 1'b0;
    tick(20);
    key[0] = 1'b0;
    tick(50);
    key = '1;
    tick(30);

    // Reset during an ON phase
    key[3] = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!m_beep_now && waited < 100) begin
        tick(1);
        waited++;
      end
      if (!m_beep_now) begin
        $display("FAIL wait_beep_on: no ON phase within %0d cycles, expected one", waited);
        $fatal(1, "burst never started");
      end
    end
    do_reset();
    tick(40);

    // Second burst starting on the first idle cycle after a single beep
    key[0] = 1'b0;
    tick(5);
    key[1] = 1'b0;
    tick(50);
    key = '1;
    tick(30);

    // Random key activity
    for (int r = 0; r < 150; r++) begin
      key = NK'($urandom);
      tick(int'($urandom_range(1, 25)));
    end
    key = '1;
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
